// File: rtl/ooo_reg_scoreboard_pkg.sv
// Shared types for the OOO register scoreboard: ROB tag type and index-width constants.
package rv32i_types_pkg;

  localparam int unsigned SB_NUM_REGS = 32;
  localparam int unsigned ROB_TAG_W   = 6;
  localparam int unsigned REG_IDX_W   = $clog2(SB_NUM_REGS);

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/ooo_reg_scoreboard_if.sv
// Dispatch/writeback/lookup bundle between decode, writeback and the register scoreboard.
interface ooo_reg_scoreboard_if
  import rv32i_types_pkg::*;
#(
  parameter int unsigned NUM_REGS = SB_NUM_REGS,
  parameter int unsigned TAG_W    = ROB_TAG_W
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic             flush;
  logic             disp_valid;
  logic             disp_wen;
  logic [IDX_W-1:0] disp_rd;
  logic [TAG_W-1:0] disp_tag;
  logic             wb_valid;
  logic [IDX_W-1:0] wb_rd;
  logic [TAG_W-1:0] wb_tag;
  logic [IDX_W-1:0] rs1_sel;
  logic [IDX_W-1:0] rs2_sel;
  logic [IDX_W-1:0] rd_sel;
  logic             rs1_busy;
  logic             rs2_busy;
  logic             rd_busy;
  logic [TAG_W-1:0] rs1_tag;
  logic [TAG_W-1:0] rs2_tag;
  logic [CNT_W-1:0] outstanding;
  logic             sb_empty;
  logic             waw_err;

  modport master (
    output flush, disp_valid, disp_wen, disp_rd, disp_tag,
    output wb_valid, wb_rd, wb_tag,
    output rs1_sel, rs2_sel, rd_sel,
    input  rs1_busy, rs2_busy, rd_busy, rs1_tag, rs2_tag,
    input  outstanding, sb_empty, waw_err
  );

  modport slave (
    input  flush, disp_valid, disp_wen, disp_rd, disp_tag,
    input  wb_valid, wb_rd, wb_tag,
    input  rs1_sel, rs2_sel, rd_sel,
    output rs1_busy, rs2_busy, rd_busy, rs1_tag, rs2_tag,
    output outstanding, sb_empty, waw_err
  );

endinterface

// File: rtl/ooo_reg_scoreboard_lookup.sv
// One scoreboard read port: busy/tag mux with x0 forced idle.
// SCOREBOARD_WB_BYPASS_EN: an accepted same-cycle writeback clears the busy result.
module ooo_sb_lookup #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned TAG_W    = 6
) (
  input  logic [$clog2(NUM_REGS)-1:0] sel,
  input  logic [NUM_REGS-1:0]         busy_vec,
  input  logic [TAG_W-1:0]            tag_vec [NUM_REGS],
`ifdef SCOREBOARD_WB_BYPASS_EN
  input  logic                        clr_en,
  input  logic [$clog2(NUM_REGS)-1:0] clr_rd,
`endif
  output logic                        busy,
  output logic [TAG_W-1:0]            tag
);

  always_comb begin
    busy = 1'b0;
    tag  = '0;
    if (sel != '0) begin
      busy = busy_vec[sel];
      tag  = tag_vec[sel];
`ifdef SCOREBOARD_WB_BYPASS_EN
      if (clr_en && (clr_rd == sel)) busy = 1'b0;
`endif
    end
  end

endmodule

// File: rtl/ooo_reg_scoreboard.sv
// Register status table: busy bit + producer ROB tag per architectural register.
// Optional macro SCOREBOARD_WB_BYPASS_EN forwards same-cycle writeback clears to lookups.
module ooo_reg_scoreboard
  import rv32i_types_pkg::*;
#(
  parameter int unsigned NUM_REGS = SB_NUM_REGS,
  parameter int unsigned TAG_W    = ROB_TAG_W
) (
  input  logic                  CLK,
  input  logic                  nRST,
  ooo_reg_scoreboard_if.slave   sb
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [NUM_REGS-1:0] busy;
  logic [TAG_W-1:0]    tags [NUM_REGS];
  logic [CNT_W-1:0]    outstanding;
  logic                waw_err;

  logic set_en, clr_hit, clr_en, inc, waw_hit;
  logic [TAG_W-1:0] rd_tag_unused;

  // A same-register set overrides the clear; since a clear implies busy, that
  // set is also a WAW overwrite, so the count stays put in that case.
  always_comb begin
    set_en  = sb.disp_valid & sb.disp_wen & (sb.disp_rd != '0) & ~sb.flush;
    clr_hit = sb.wb_valid & (sb.wb_rd != '0) & busy[sb.wb_rd] &
              (tags[sb.wb_rd] == sb.wb_tag) & ~sb.flush;
    clr_en  = clr_hit & ~(set_en & (sb.disp_rd == sb.wb_rd));
    inc     = set_en & ~busy[sb.disp_rd];
    waw_hit = set_en & busy[sb.disp_rd];
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      busy        <= '0;
      outstanding <= '0;
      waw_err     <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) tags[i] <= '0;
    end else begin
      waw_err <= waw_hit;
      if (sb.flush) begin
        busy        <= '0;
        outstanding <= '0;
      end else begin
        if (clr_en) busy[sb.wb_rd] <= 1'b0;
        if (set_en) begin
          busy[sb.disp_rd] <= 1'b1;
          tags[sb.disp_rd] <= sb.disp_tag;
        end
        case ({inc, clr_en})
          2'b10:   outstanding <= outstanding + CNT_W'(1);
          2'b01:   outstanding <= outstanding - CNT_W'(1);
          default: outstanding <= outstanding;
        endcase
      end
    end
  end

  assign sb.outstanding = outstanding;
  assign sb.sb_empty    = (outstanding == '0);
  assign sb.waw_err     = waw_err;

  ooo_sb_lookup #(.NUM_REGS(NUM_REGS), .TAG_W(TAG_W)) u_rs1 (
    .sel      (sb.rs1_sel),
    .busy_vec (busy),
    .tag_vec  (tags),
`ifdef SCOREBOARD_WB_BYPASS_EN
    .clr_en   (clr_en),
    .clr_rd   (sb.wb_rd),
`endif
    .busy     (sb.rs1_busy),
    .tag      (sb.rs1_tag)
  );

  ooo_sb_lookup #(.NUM_REGS(NUM_REGS), .TAG_W(TAG_W)) u_rs2 (
    .sel      (sb.rs2_sel),
    .busy_vec (busy),
    .tag_vec  (tags),
`ifdef SCOREBOARD_WB_BYPASS_EN
    .clr_en   (clr_en),
    .clr_rd   (sb.wb_rd),
`endif
    .busy     (sb.rs2_busy),
    .tag      (sb.rs2_tag)
  );

  ooo_sb_lookup #(.NUM_REGS(NUM_REGS), .TAG_W(TAG_W)) u_rd (
    .sel      (sb.rd_sel),
    .busy_vec (busy),
    .tag_vec  (tags),
`ifdef SCOREBOARD_WB_BYPASS_EN
    .clr_en   (clr_en),
    .clr_rd   (sb.wb_rd),
`endif
    .busy     (sb.rd_busy),
    .tag      (rd_tag_unused)
  );

endmodule
